// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the I/D memory port arbiter.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_MEM_LAT = 1;
  // MEM_LAT tops out at 7, so the countdown fits in 3 bits.
  localparam int LAT_W       = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requesters.
// MEM_ARB_ROUND_ROBIN_EN selects the history-based tie-break; otherwise D wins ties.
module mem_arb_pick
  import cpu_mem_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic last_own,
`endif
  output logic grant,
  output logic owner
);

  assign grant = i_req | d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // A tie goes to whoever lost last time; a lone requester always wins.
  assign owner = (i_req & d_req) ? ~last_own : (d_req ? OWN_D : OWN_I);
`else
  assign owner = d_req ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous SRAM between fetch (I) and load/store (D).
// Build option: MEM_ARB_ROUND_ROBIN_EN enables round-robin tie-breaking.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                m_en,
  output logic                m_we,
  output logic [ADDR_W-3:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int WA_W   = ADDR_W - 2;

  arb_state_t          r_state, w_next;
  logic                r_own;
  logic                r_we;
  logic [WA_W-1:0]     r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic [LAT_W-1:0]    r_lat;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_grant, w_owner;
  logic                w_issue, w_resp;

  // Byte offset within the word is deliberately dropped.
  logic w_unused_addr_lsb;
  assign w_unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last;

  mem_arb_pick u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
    .last_own (r_last),
    .grant    (w_grant),
    .owner    (w_owner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_last <= OWN_D;
    else if (r_state == ST_IDLE && w_grant)  r_last <= w_owner;
  end
`else
  mem_arb_pick u_pick (
    .i_req (i_req),
    .d_req (d_req),
    .grant (w_grant),
    .owner (w_owner)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (r_lat == '0) w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_own   <= OWN_I;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_lat   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_grant) begin
          r_own   <= w_owner;
          r_we    <= (w_owner == OWN_D) & d_we;
          r_addr  <= (w_owner == OWN_D) ? d_addr[ADDR_W-1:2] : i_addr[ADDR_W-1:2];
          r_wdata <= (w_owner == OWN_D) ? d_wdata : '0;
          // Loads carry no byte enables to the SRAM.
          r_wstrb <= ((w_owner == OWN_D) && d_we) ? d_wstrb : '0;
        end
        ST_ISSUE: r_lat <= LAT_W'(MEM_LAT - 1);
        ST_WAIT: begin
          if (r_lat != '0) r_lat   <= r_lat - 1'b1;
          else             r_rdata <= r_we ? '0 : m_rdata;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  assign w_issue = (r_state == ST_ISSUE);
  assign w_resp  = (r_state == ST_RESP);

  assign m_en    = w_issue;
  assign m_we    = w_issue & r_we;
  assign m_addr  = w_issue ? r_addr  : '0;
  assign m_wdata = w_issue ? r_wdata : '0;
  assign m_wstrb = w_issue ? r_wstrb : '0;

  assign i_ack   = w_resp & (r_own == OWN_I);
  assign d_ack   = w_resp & (r_own == OWN_D);
  assign i_rdata = i_ack ? r_rdata : '0;
  assign d_rdata = d_ack ? r_rdata : '0;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural SRAM (MEM_LAT=1).
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 1;

  logic          clk, rst_n;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, i_rdata, d_rdata, m_wdata, m_rdata;
  logic [3:0]    d_wstrb, m_wstrb;
  logic          i_ack, d_ack, m_en, m_we, busy;
  logic [AW-3:0] m_addr;

  typedef struct { logic port; logic [31:0] data; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int errors = 0;
  int checks = 0;

  logic [31:0] sram    [0:255];
  logic [31:0] ref_mem [0:255];
  bit          pre_done = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'hFFFF_FFFF;
    if (i == 2) return 32'hDEAD_BEEF;
    return {4{8'(i)}};
  endfunction

  // Behavioural SRAM, one-cycle read latency.
  always @(posedge clk) begin
    if (!pre_done) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
      m_rdata  <= '0;
      pre_done <= 1'b1;
    end else if (m_en) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_wstrb[b]) sram[m_addr[7:0]][8*b +: 8] <= m_wdata[8*b +: 8];
      end else begin
        m_rdata <= sram[m_addr[7:0]];
      end
    end
  end

  always @(negedge clk) begin
    if (i_ack && d_ack) begin
      checks++; errors++;
      $display("FAIL dual_ack: both acks high");
    end else if (i_ack || d_ack) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: port=%0d rdata=%h with empty scoreboard", d_ack, d_ack ? d_rdata : i_rdata);
      end else begin
        mon_e = sb.pop_front();
        if (d_ack !== mon_e.port || (d_ack ? d_rdata : i_rdata) !== mon_e.data ||
            (d_ack ? i_rdata : d_rdata) !== 32'h0) begin
          errors++;
          $display("FAIL sb_ack: port=%0d data=%h other=%h, expected port=%0d data=%h other=0",
                   d_ack, d_ack ? d_rdata : i_rdata, d_ack ? i_rdata : d_rdata, mon_e.port, mon_e.data);
        end
      end
    end
  end

  task automatic idle_inputs();
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
  endtask

  task automatic ref_write(input logic [7:0] w, input logic [31:0] wd, input logic [3:0] st);
    for (int b = 0; b < 4; b++)
      if (st[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic push_load(input logic port, input logic [31:0] addr);
    exp_t e;
    e.port = port; e.data = ref_mem[addr[9:2]];
    sb.push_back(e);
  endtask

  task automatic access(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb, input string nm);
    exp_t e;
    int   en_cnt = 0;
    int   ack_c  = 0;
    bit   done   = 0;
    e.port = port; e.data = we ? 32'h0 : ref_mem[addr[9:2]];
    if (we) ref_write(addr[9:2], wdata, wstrb);
    sb.push_back(e);
    @(negedge clk);
    if (port) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb; end
    else begin i_req = 1; i_addr = addr; end
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clk);
      if (m_en) begin
        en_cnt++; checks++;
        if (c != 1 || m_addr !== addr[31:2] || m_we !== we || m_wstrb !== (we ? wstrb : 4'h0) ||
            (we && m_wdata !== wdata)) begin
          errors++;
          $display("FAIL %s issue: cycle=%0d addr=%h we=%b strb=%h wdata=%h, expected cycle=1 addr=%h we=%b strb=%h wdata=%h",
                   nm, c, m_addr, m_we, m_wstrb, m_wdata, addr[31:2], we, we ? wstrb : 4'h0, wdata);
        end
      end
      if (i_ack || d_ack) begin done = 1; ack_c = c; idle_inputs(); end
    end
    checks++;
    if (!done || ack_c != 2 + LAT) begin
      errors++;
      $display("FAIL %s latency: ack at cycle %0d (0=none), expected %0d", nm, ack_c, 2 + LAT);
    end
    checks++;
    if (en_cnt != 1) begin
      errors++;
      $display("FAIL %s m_en_count: %0d, expected 1", nm, en_cnt);
    end
    idle_inputs();
  endtask

  task automatic hold_both(input int n, input int drop_d_at, input string nm);
    int k = 0;
    @(negedge clk);
    i_req = 1; i_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'h10;
    for (int c = 0; c < 80 && k < n; c++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        k++;
        if (d_ack && k == drop_d_at) d_req = 0;
      end
    end
    idle_inputs();
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL %s ack_count: %0d, expected %0d", nm, k, n);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({i_ack, d_ack, m_en, m_we, busy, i_rdata, d_rdata, m_addr, m_wdata, m_wstrb} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b m_en=%b acks=%b%b, expected all 0", busy, m_en, i_ack, d_ack);
    end
    rst_n = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({i_ack, d_ack, m_en, m_we, busy, i_rdata, d_rdata, m_addr, m_wdata, m_wstrb} !== '0) begin
        errors++;
        $display("FAIL idle_outputs: cycle %0d busy=%b m_en=%b m_addr=%h, expected all 0", c, busy, m_en, m_addr);
      end
    end
  endtask

  task automatic test_fetch();
    access(OWN_I, 0, 32'h8, '0, '0, "fetch");
    access(OWN_I, 0, 32'hB, '0, '0, "fetch_unaligned");
  endtask

  task automatic test_store_load();
    access(OWN_D, 1, 32'h10, 32'h1234_5678, 4'hF, "store_full");
    access(OWN_D, 0, 32'h10, '0, '0, "load_full");
  endtask

  task automatic test_partial_store();
    access(OWN_D, 1, 32'h0, 32'h0, 4'h3, "store_partial");
    access(OWN_D, 0, 32'h0, '0, '0, "load_partial");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_req = 1; i_addr = 32'h8;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || m_en !== 1'b0 || i_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b m_en=%b i_ack=%b, expected 0 0 0", busy, m_en, i_ack);
    end
    idle_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1;
    access(OWN_I, 0, 32'h8, '0, '0, "fetch_after_reset");
  endtask

  task automatic test_contention();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push_load(OWN_I, 32'h8); push_load(OWN_D, 32'h10); push_load(OWN_I, 32'h8);
`else
    push_load(OWN_D, 32'h10); push_load(OWN_D, 32'h10); push_load(OWN_D, 32'h10);
`endif
    hold_both(3, 0, "contend_held");
    push_load(OWN_D, 32'h10); push_load(OWN_I, 32'h8);
    hold_both(2, 1, "contend_drop_d");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_fetch();
    test_store_load();
    test_partial_store();
    test_reset_mid();
    test_contention();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected acks never seen, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
